share_seq_ctrl: RTL and testbench

- Sequences one masked TBC block through the share-interleaved bus interface.
- Loads bus words into an interleaved state register and drives that register into the share router's statein.
- Fires the TBC and captures the router's stateout when the TBC finishes.
- Unloads the result word by word, then zeroizes the register.

---
 rtl/share_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_share_seq_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/share_seq_ctrl.sv
// share_seq_ctrl
// Sequences one masked TBC block through the share-interleaved bus interface:
// words are loaded into an interleaved state register that feeds the share
// router, the TBC is fired, its result is captured from the router, and the
// result is unloaded word by word before the register is zeroized.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               begin a block (only honoured in IDLE)
//   in_data/in_valid    input bus word and its valid
//   in_ready            high while the block is accepting input words
//   tbc_start           one-cycle pulse that launches the TBC
//   tbc_done            TBC finished; state_next is valid this cycle
//   state_q             interleaved state register, drives router statein
//   state_next          interleaved next state from router stateout
//   out_data/out_valid  output bus word and its valid
//   out_ready           consumer accepts out_data
//   busy                high in every state except IDLE
//
// Word k of the bus occupies state_q[k*BUSW +: BUSW]; with k = j*SHARES+i this
// is word j of share i. The same single pointer is used for load and unload.
module share_seq_ctrl #(
  parameter int BUSW   = 32,
  parameter int SHARES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BUSW-1:0]         in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    tbc_start,
  input  logic                    tbc_done,
  output logic [128*SHARES-1:0]   state_q,
  input  logic [128*SHARES-1:0]   state_next,
  output logic [BUSW-1:0]         out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int SW    = 128 * SHARES;
  localparam int WORDS = SW / BUSW;
  // Keep the counter at least one bit wide so a single-word block still elaborates.
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FIRE  = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4
  } fsm_e;

  fsm_e            fsm_q, fsm_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;
  logic [SW-1:0]   shreg_q, shreg_d;
  logic [BUSW-1:0] obuf_q, obuf_d;

  assign cnt_inc = cnt_q + CW'(1);

  // Next-state logic. out_data is held in its own register (obuf) which is
  // preloaded with the word that will be presented next, so the bus word is
  // registered and cannot change while the consumer stalls.
  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    obuf_d  = obuf_q;
    unique case (fsm_q)
      IDLE: begin
        if (start) begin
          fsm_d = LOAD;
          cnt_d = '0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          shreg_d[int'(cnt_q)*BUSW +: BUSW] = in_data;
          if (cnt_q == LAST) begin
            cnt_d = '0;
            fsm_d = FIRE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      FIRE: begin
        fsm_d = RUN;
      end
      RUN: begin
        if (tbc_done) begin
          shreg_d = state_next;
          obuf_d  = state_next[BUSW-1:0];
          cnt_d   = '0;
          fsm_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (cnt_q == LAST) begin
            // Last word handed over: wipe the shares so nothing lingers.
            shreg_d = '0;
            obuf_d  = '0;
            cnt_d   = '0;
            fsm_d   = IDLE;
          end else begin
            cnt_d  = cnt_inc;
            obuf_d = shreg_q[int'(cnt_inc)*BUSW +: BUSW];
          end
        end
      end
      default: begin
        fsm_d = IDLE;
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      obuf_q  <= '0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      obuf_q  <= obuf_d;
    end
  end

  // Handshake outputs depend only on the state register, so there is no
  // combinational path from in_valid/out_ready back to in_ready/out_valid.
  assign in_ready  = (fsm_q == LOAD);
  assign tbc_start = (fsm_q == FIRE);
  assign out_valid = (fsm_q == DRAIN);
  assign busy      = (fsm_q != IDLE);
  assign out_data  = obuf_q;
  assign state_q   = shreg_q;

endmodule

// File: tb/tb_share_seq_ctrl.sv
// tb_share_seq_ctrl
// Self-checking bench for share_seq_ctrl (BUSW=32, SHARES=2, 8 words/block).
// The stimulus side loads random or directed blocks, models the TBC/router as
// "state_next = state_q XOR replicated mask" after 40 cycles, and pushes the
// expected output words (loaded word XOR mask) into a queue. A separate
// monitor pops that queue on every output handshake and also checks that
// out_data holds steady while the consumer stalls.
module tb_share_seq_ctrl;

  localparam int BUSW   = 32;
  localparam int SHARES = 2;
  localparam int WORDS  = 8;
  localparam int SW     = 128 * SHARES;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [BUSW-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic            tbc_start;
  logic            tbc_done;
  logic [SW-1:0]   state_q;
  logic [SW-1:0]   state_next;
  logic [BUSW-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic            busy;

  always #5 clk = ~clk;

  share_seq_ctrl #(.BUSW(BUSW), .SHARES(SHARES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tbc_start  (tbc_start),
    .tbc_done   (tbc_done),
    .state_q    (state_q),
    .state_next (state_next),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  int              total = 0;
  int              bad   = 0;
  int              tbcCount = 0;
  logic [BUSW-1:0] expQ[$];
  logic [BUSW-1:0] curWords[WORDS];
  bit              stallPending = 1'b0;
  logic [BUSW-1:0] stallData;

  task automatic checkOutput(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SW-1:0] rand256();
    logic [SW-1:0] v;
    for (int i = 0; i < SW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic checkZeros(input string tag);
    checkOutput({tag, " ctrl outs"}, {in_ready, out_valid, tbc_start, busy}, 0);
    checkOutput({tag, " out_data"}, out_data, 0);
    checkOutput({tag, " state_q"}, state_q, 0);
  endtask

  // Asynchronous reset pulse issued mid-cycle; outputs must clear at once.
  task automatic doReset(input string tag);
    #1 rst_n = 1'b0;
    #1 checkZeros(tag);
    expQ.delete();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    start     = 1'b0;
    tbc_done  = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  // Output monitor: scoreboard pop on handshake plus stall-stability check.
  always @(negedge clk) begin
    if (tbc_start) tbcCount++;
    if (!rst_n) begin
      stallPending = 1'b0;
    end else begin
      if (stallPending && out_valid) checkOutput("stalled out_data stable", out_data, stallData);
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected out word: got %h expected none", out_data);
        end else begin
          checkOutput("out word", out_data, expQ.pop_front());
        end
        stallPending = 1'b0;
      end else if (out_valid) begin
        stallPending = 1'b1;
        stallData    = out_data;
      end else begin
        stallPending = 1'b0;
      end
    end
  end

  // Runs one block. abortLoad/abortDrain > 0 reset the DUT after that many
  // accepted/drained words. skipStart assumes the previous block chained a start.
  task automatic applyStimulus(input bit directed, input bit gaps, input bit stall,
                               input bit spurious, input int abortLoad, input int abortDrain,
                               input bit skipStart, input bit chainNext);
    logic [BUSW-1:0] mask;
    logic [SW-1:0]   expState;
    int              k, n, budget, stallCnt, startCount;
    bit              hs, first, spurDone;

    for (int i = 0; i < WORDS; i++) curWords[i] = directed ? (32'h1000_0000 + 32'(i)) : $urandom;
    mask = directed ? 32'hA5A5_A5A5 : $urandom;
    for (int i = 0; i < WORDS; i++) expState[i*BUSW +: BUSW] = curWords[i];

    if (!skipStart) begin
      start = 1'b1;
      @(negedge clk);
      checkOutput("idle before start", busy, 0);
      tick();
      start = 1'b0;
    end
    startCount = tbcCount;

    k = 0;
    budget = 200;
    while (k < WORDS && budget > 0) begin
      if (abortLoad > 0 && k == abortLoad) begin
        in_valid = 1'b0;
        doReset("load abort");
        return;
      end
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = in_valid ? curWords[k] : $urandom;
      if (spurious && k == 2) begin
        start      = 1'b1;
        tbc_done   = 1'b1;
        state_next = rand256();
      end
      @(negedge clk);
      checkOutput("in_ready in load", in_ready, 1);
      hs = in_valid && in_ready;
      tick();
      start    = 1'b0;
      tbc_done = 1'b0;
      if (hs) k++;
      budget--;
    end
    in_valid = 1'b0;
    if (budget == 0) begin
      failNow("load timeout");
      doReset("load timeout");
      return;
    end

    @(negedge clk);
    checkOutput("tbc_start after last word", tbc_start, 1);
    checkOutput("in_ready dropped", in_ready, 0);
    checkOutput("loaded state", state_q, expState);
    tick();

    for (int c = 0; c < 40; c++) begin
      out_ready = ($urandom_range(0, 1) == 1);
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = $urandom;
      if (spurious && c == 10) start = 1'b1;
      tick();
      start = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    @(negedge clk);
    checkOutput("state held in run", state_q, expState);
    checkOutput("tbc_start pulses", tbcCount - startCount, 1);
    checkOutput("busy in run", busy, 1);
    checkOutput("no out_valid in run", out_valid, 0);
    tbc_done   = 1'b1;
    state_next = state_q ^ {(SW / BUSW){mask}};
    for (int i = 0; i < WORDS; i++) expQ.push_back(curWords[i] ^ mask);
    tick();
    tbc_done   = 1'b0;
    state_next = rand256();

    n = 0;
    budget = 300;
    stallCnt = 0;
    first = 1'b1;
    spurDone = 1'b0;
    while (n < WORDS && budget > 0) begin
      if (abortDrain > 0 && n == abortDrain) begin
        out_ready = 1'b0;
        doReset("drain abort");
        return;
      end
      if (stall && n == 3 && stallCnt < 5) begin
        out_ready = 1'b0;
        stallCnt++;
      end else begin
        out_ready = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
      if (spurious && n == 5 && !spurDone) begin
        start      = 1'b1;
        tbc_done   = 1'b1;
        state_next = rand256();
        spurDone   = 1'b1;
      end
      @(negedge clk);
      if (first) begin
        checkOutput("first out_valid latency", out_valid, 1);
        first = 1'b0;
      end
      if (out_valid && out_ready) n++;
      tick();
      start    = 1'b0;
      tbc_done = 1'b0;
      budget--;
    end
    out_ready = 1'b0;
    if (budget == 0) begin
      failNow("drain timeout");
      doReset("drain timeout");
      return;
    end

    if (chainNext) start = 1'b1;
    @(negedge clk);
    checkOutput("zeroized state", state_q, 0);
    checkOutput("busy after drain", busy, 0);
    checkOutput("out_valid after drain", out_valid, 0);
    checkOutput("all words drained", expQ.size(), 0);
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    tbc_done   = 1'b0;
    out_ready  = 1'b0;
    state_next = '0;
    #2 checkZeros("reset");
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Traffic on every input while idle must not disturb anything.
    for (int c = 0; c < 3; c++) begin
      in_valid   = 1'b1;
      in_data    = $urandom;
      out_ready  = 1'b1;
      tbc_done   = 1'b1;
      state_next = rand256();
      @(negedge clk);
      checkOutput("idle state_q", state_q, 0);
      checkOutput("idle busy/in_ready", {busy, in_ready}, 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tbc_done  = 1'b0;

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 3, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
